da_serial_driver: RTL and testbench

Serial DAC interface stage that sits directly downstream of the waveform sample generator. On each one-cycle `da_start` strobe it captures the 10-bit `da_data` sample and shifts it out as a 12-bit frame: 10 data bits MSB first, then 2 zero fill bits. The frame goes to an external TLC5615-class serial DAC over chip-select, serial-clock and data lines. It reports busy, frame-done and dropped-start status to the surrounding control logic.

---
 rtl/da_serial_driver.sv | 168 ++++++++++++++++
 tb/tb_da_serial_driver.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/da_serial_driver.sv
// Serial DAC frame driver: captures a 10-bit sample on da_start and shifts a
// 12-bit frame (10 data bits MSB first + 2 zero fill bits) out on cs_n/sclk/din.
module da_serial_driver #(
    parameter int unsigned SCLK_HALF = 2,
    parameter int unsigned CS_SETUP  = 1,
    parameter int unsigned CS_HOLD   = 1
) (
    input  logic       CLK_50M,
    input  logic       RST_N,
    input  logic [9:0] da_data,
    input  logic       da_start,
    output logic       da_cs_n,
    output logic       da_sclk,
    output logic       da_din,
    output logic       da_busy,
    output logic       da_done,
    output logic       da_overrun
);

    localparam int unsigned DW     = 10;
    localparam int unsigned FW     = 12;
    localparam int unsigned BW     = 4;
    localparam int unsigned PH_W   = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int unsigned CS_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned CW     = (CS_MAX > 1) ? $clog2(CS_MAX) : 1;

    localparam logic [PH_W-1:0] PH_LAST    = PH_W'(SCLK_HALF - 1);
    localparam logic [CW-1:0]   SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0]   HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [BW-1:0]   BIT_LAST   = BW'(FW - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [FW-1:0]   shreg_q, shreg_d;
    logic [BW-1:0]   bit_q,   bit_d;
    logic [PH_W-1:0] ph_q,    ph_d;
    logic            hi_q,    hi_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    logic cs_n_q,    cs_n_d;
    logic sclk_q,    sclk_d;
    logic din_q,     din_d;
    logic busy_q,    busy_d;
    logic done_q,    done_d;
    logic overrun_q, overrun_d;

    // State, datapath and output registers
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_q     <= '0;
            ph_q      <= '0;
            hi_q      <= 1'b0;
            cnt_q     <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            din_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_q     <= bit_d;
            ph_q      <= ph_d;
            hi_q      <= hi_d;
            cnt_q     <= cnt_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            din_q     <= din_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state: SETUP/HOLD count cnt_q, SHIFT walks low/high half-phases per bit
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        ph_d    = ph_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                bit_d = '0;
                ph_d  = '0;
                hi_d  = 1'b0;
                cnt_d = '0;
                if (da_start) begin
                    shreg_d = {da_data, (FW - DW)'(0)};
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SHIFT: begin
                if (ph_q == PH_LAST) begin
                    ph_d = '0;
                    if (!hi_q) begin
                        hi_d = 1'b1;
                    end else begin
                        hi_d    = 1'b0;
                        shreg_d = {shreg_q[FW-2:0], 1'b0};
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            state_d = S_HOLD;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs follow the current state; done marks the first idle cycle after busy
    always_comb begin
        cs_n_d    = 1'b1;
        sclk_d    = 1'b0;
        din_d     = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        overrun_d = 1'b0;
        if (state_q == S_IDLE) begin
            done_d = busy_q;
        end else begin
            cs_n_d    = 1'b0;
            busy_d    = 1'b1;
            din_d     = shreg_q[FW-1];
            sclk_d    = (state_q == S_SHIFT) && hi_q;
            overrun_d = da_start;
        end
    end

    assign da_cs_n    = cs_n_q;
    assign da_sclk    = sclk_q;
    assign da_din     = din_q;
    assign da_busy    = busy_q;
    assign da_done    = done_q;
    assign da_overrun = overrun_q;

endmodule

// File: tb/tb_da_serial_driver.sv
// Bench for da_serial_driver: a default instance and a fast-SCLK instance, with
// a negedge frame monitor that reconstructs each frame as the DAC would see it.
module tb_da_serial_driver;

    logic             clk;
    logic             rst_n;
    logic [1:0][9:0]  data;
    logic [1:0]       start;
    logic [1:0]       cs_n, sclk, din, busy, done, ovr;

    int checks = 0;
    int errors = 0;

    // Per-instance expected timing: instance 0 defaults, instance 1 fast
    int exp_len [2] = '{1 + 24 * 2 + 1, 2 + 24 * 1 + 3};
    int exp_per [2] = '{4, 2};

    da_serial_driver u_dut0 (
        .CLK_50M(clk), .RST_N(rst_n), .da_data(data[0]), .da_start(start[0]),
        .da_cs_n(cs_n[0]), .da_sclk(sclk[0]), .da_din(din[0]),
        .da_busy(busy[0]), .da_done(done[0]), .da_overrun(ovr[0])
    );

    da_serial_driver #(.SCLK_HALF(1), .CS_SETUP(2), .CS_HOLD(3)) u_dut1 (
        .CLK_50M(clk), .RST_N(rst_n), .da_data(data[1]), .da_start(start[1]),
        .da_cs_n(cs_n[1]), .da_sclk(sclk[1]), .da_din(din[1]),
        .da_busy(busy[1]), .da_done(done[1]), .da_overrun(ovr[1])
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Frame monitor state and recorded frames
    int          cyc = 0;
    int          acc_len [2], acc_edges [2], last_rise [2], pmin [2], pmax [2];
    logic [11:0] acc_word [2];
    logic        prev_sclk [2], prev_cs [2];
    int          fr_cnt [2] = '{0, 0};
    int          done_cnt [2] = '{0, 0};
    int          ovr_cnt [2] = '{0, 0};
    int          fr_len [2][32], fr_edges [2][32], fr_pmin [2][32], fr_pmax [2][32];
    logic [11:0] fr_word [2][32];
    logic        fr_done [2][32];
    int          per_tmp;

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                acc_len[i] = 0; acc_edges[i] = 0; acc_word[i] = '0;
                last_rise[i] = -1; pmin[i] = 1000; pmax[i] = 0;
                prev_sclk[i] = 1'b0; prev_cs[i] = 1'b1;
            end else begin
                if (!cs_n[i]) acc_len[i]++;
                if (sclk[i] && !prev_sclk[i]) begin
                    acc_word[i] = {acc_word[i][10:0], din[i]};
                    acc_edges[i]++;
                    if (last_rise[i] >= 0) begin
                        per_tmp = cyc - last_rise[i];
                        if (per_tmp < pmin[i]) pmin[i] = per_tmp;
                        if (per_tmp > pmax[i]) pmax[i] = per_tmp;
                    end
                    last_rise[i] = cyc;
                end
                if (cs_n[i] && !prev_cs[i]) begin
                    if (fr_cnt[i] < 32) begin
                        fr_len[i][fr_cnt[i]]   = acc_len[i];
                        fr_word[i][fr_cnt[i]]  = acc_word[i];
                        fr_edges[i][fr_cnt[i]] = acc_edges[i];
                        fr_pmin[i][fr_cnt[i]]  = pmin[i];
                        fr_pmax[i][fr_cnt[i]]  = pmax[i];
                        fr_done[i][fr_cnt[i]]  = done[i] && !busy[i];
                    end
                    fr_cnt[i]++;
                    acc_len[i] = 0; acc_edges[i] = 0; acc_word[i] = '0;
                    last_rise[i] = -1; pmin[i] = 1000; pmax[i] = 0;
                end
                if (done[i]) done_cnt[i]++;
                if (ovr[i]) ovr_cnt[i]++;
                prev_sclk[i] = sclk[i];
                prev_cs[i]   = cs_n[i];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int i, input logic [9:0] d);
        @(negedge clk);
        start[i] = 1'b1;
        data[i]  = d;
        @(negedge clk);
        start[i] = 1'b0;
        data[i]  = 10'($urandom);
    endtask

    task automatic wait_frames(input int i, input int n);
        int budget = 3000;
        while (fr_cnt[i] < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("frame_timeout", 32'(fr_cnt[i] >= n), 32'd1);
    endtask

    task automatic check_frame(input int i, input int k, input logic [9:0] d, input string tag);
        logic [11:0] exp_word;
        exp_word = {d, 2'b00};
        chk({tag, "_word"},  32'(fr_word[i][k]), 32'(exp_word));
        chk({tag, "_len"},   32'(fr_len[i][k]), 32'(exp_len[i]));
        chk({tag, "_edges"}, 32'(fr_edges[i][k]), 32'd12);
        chk({tag, "_pmin"},  32'(fr_pmin[i][k]), 32'(exp_per[i]));
        chk({tag, "_pmax"},  32'(fr_pmax[i][k]), 32'(exp_per[i]));
        chk({tag, "_done"},  32'(fr_done[i][k]), 32'd1);
    endtask

    initial begin
        logic [9:0] base;
        logic [9:0] seq [8];
        logic [9:0] a, b;
        int n0;

        rst_n = 1'b0;
        start = '0;
        data  = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs0", 32'({cs_n[0], sclk[0], din[0], busy[0], done[0], ovr[0]}), 32'b100000);
        chk("reset_outs1", 32'({cs_n[1], sclk[1], din[1], busy[1], done[1], ovr[1]}), 32'b100000);
        rst_n = 1'b1;
        @(negedge clk);

        // Single 2AB frame: cs_n falls one edge after the capturing edge
        send(0, 10'h2AB);
        chk("lat_cs_still_high", 32'(cs_n[0]), 32'd1);
        @(negedge clk);
        chk("lat_cs_low", 32'(cs_n[0]), 32'd0);
        chk("lat_busy", 32'(busy[0]), 32'd1);
        wait_frames(0, 1);
        check_frame(0, 0, 10'h2AB, "f2ab");
        chk("f2ab_done_cnt", 32'(done_cnt[0]), 32'd1);

        // Extremes
        send(0, 10'h000);
        wait_frames(0, 2);
        check_frame(0, 1, 10'h000, "fmin");
        send(0, 10'h3FF);
        wait_frames(0, 3);
        check_frame(0, 2, 10'h3FF, "fmax");

        // Eight frames on a 97-cycle cadence
        n0   = fr_cnt[0];
        base = 10'($urandom_range(0, 1023));
        for (int k = 0; k < 8; k++) begin
            seq[k] = base + 10'(k);
            send(0, seq[k]);
            repeat (95) @(negedge clk);
        end
        wait_frames(0, n0 + 8);
        for (int k = 0; k < 8; k++) check_frame(0, n0 + k, seq[k], "cad");
        chk("cad_no_overrun", 32'(ovr_cnt[0]), 32'd0);

        // Start while busy: overrun pulse, frame keeps original data
        n0 = fr_cnt[0];
        a  = 10'($urandom);
        b  = ~a;
        send(0, a);
        repeat (19) @(negedge clk);
        start[0] = 1'b1;
        data[0]  = b;
        @(negedge clk);
        start[0] = 1'b0;
        chk("ovr_pulse", 32'(ovr[0]), 32'd1);
        @(negedge clk);
        chk("ovr_one_cycle", 32'(ovr[0]), 32'd0);
        wait_frames(0, n0 + 1);
        check_frame(0, n0, a, "ovr_frame");
        repeat (120) @(negedge clk);
        chk("ovr_no_second", 32'(fr_cnt[0]), 32'(n0 + 1));
        chk("ovr_idle", 32'(busy[0]), 32'd0);

        // Asynchronous reset mid-frame
        n0 = fr_cnt[0];
        send(0, 10'($urandom));
        repeat (28) @(negedge clk);
        chk("rst_mid_cs_low", 32'(cs_n[0]), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_outs", 32'({cs_n[0], sclk[0], din[0], busy[0], done[0], ovr[0]}), 32'b100000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_partial_dropped", 32'(fr_cnt[0]), 32'(n0));
        a = 10'($urandom);
        send(0, a);
        wait_frames(0, n0 + 1);
        check_frame(0, n0, a, "rst_clean");

        // Fast instance: SCLK_HALF=1, CS_SETUP=2, CS_HOLD=3
        send(1, 10'h3FF);
        wait_frames(1, 1);
        check_frame(1, 0, 10'h3FF, "alt_max");
        send(1, 10'h000);
        wait_frames(1, 2);
        check_frame(1, 1, 10'h000, "alt_min");
        for (int k = 0; k < 3; k++) begin
            a = 10'($urandom);
            send(1, a);
            wait_frames(1, 3 + k);
            check_frame(1, 2 + k, a, "alt_rand");
        end

        repeat (5) @(negedge clk);
        chk("done_matches_frames0", 32'(done_cnt[0]), 32'(fr_cnt[0]));
        chk("done_matches_frames1", 32'(done_cnt[1]), 32'(fr_cnt[1]));
        chk("overrun_total0", 32'(ovr_cnt[0]), 32'd1);
        chk("overrun_total1", 32'(ovr_cnt[1]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
